// File: rtl/credit_txn_controller.sv
// credit_txn_controller: multi-user credit engine (IDLE/AUTH/RECOMMEND/TRANSACTION/UPDATE/REJECT).
// Optional RECOMMEND selection timeout is built when CREDIT_SEL_TIMEOUT_EN is defined.
module credit_txn_controller #(
  parameter int NUM_USERS    = 8,
  parameter int CREDIT_W     = 8,
  parameter int AUTH_CYCLES  = 10,
  parameter int RESET_CREDIT = 255,
  parameter int SEL_TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         meal_request,
  input  logic [$clog2(NUM_USERS)-1:0] user_id,
  input  logic [CREDIT_W-1:0]          meal_cost,
  input  logic                         user_select,
  input  logic                         cancel,
  input  logic                         refill,
  input  logic [CREDIT_W-1:0]          refill_amount,
  input  logic [$clog2(NUM_USERS)-1:0] query_id,
  output logic [CREDIT_W-1:0]          query_balance,
  output logic [2:0]                   state,
  output logic                         busy,
  output logic [CREDIT_W-1:0]          balance_out,
  output logic                         txn_done,
  output logic                         txn_ok,
  output logic                         insufficient
);
  localparam int IDW   = $clog2(NUM_USERS);
  localparam int IDW1  = IDW + 1;
  localparam int CNT_W = (AUTH_CYCLES > 1) ? $clog2(AUTH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(AUTH_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1'b1);
  localparam logic [IDW:0]        USERS_W   = IDW1'(NUM_USERS);
  localparam logic [CREDIT_W-1:0] RESET_VAL = CREDIT_W'(RESET_CREDIT);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_AUTH        = 3'd1,
    ST_RECOMMEND   = 3'd2,
    ST_TRANSACTION = 3'd3,
    ST_UPDATE      = 3'd4,
    ST_REJECT      = 3'd5
  } state_e;

  state_e              state_r, state_nxt_s;
  logic [CREDIT_W-1:0] bal_r [NUM_USERS];
  logic [IDW-1:0]      uid_r;
  logic [CREDIT_W-1:0] cost_r, bout_r, sel_bal_s, new_bal_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r, done_r, ok_r, insuf_r;
  logic                insuf_nxt_s, latch_s, refill_s, load_bout_s, commit_s;

  // Saturating add: a CREDIT_W+1 bit sum clamps to all-ones on carry out.
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
  endfunction

  // Balance of the latched user; an out-of-range ID reads as zero.
  always_comb begin
    sel_bal_s = {CREDIT_W{1'b0}};
    if ({1'b0, uid_r} < USERS_W) begin
      sel_bal_s = bal_r[uid_r];
    end else begin
      sel_bal_s = {CREDIT_W{1'b0}};
    end
    new_bal_s = sel_bal_s - cost_r;
  end

  // Debug read port.
  always_comb begin
    query_balance = {CREDIT_W{1'b0}};
    if ({1'b0, query_id} < USERS_W) begin
      query_balance = bal_r[query_id];
    end else begin
      query_balance = {CREDIT_W{1'b0}};
    end
  end

`ifdef CREDIT_SEL_TIMEOUT_EN
  localparam int SEL_W = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1'b1);
  logic [SEL_W-1:0] sel_cnt_r;

  // Counts cycles spent waiting in RECOMMEND; cleared whenever it is left or entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cnt_r <= {SEL_W{1'b0}};
    end else if (state_r == ST_RECOMMEND && state_nxt_s == ST_RECOMMEND) begin
      sel_cnt_r <= sel_cnt_r + SEL_ONE;
    end else begin
      sel_cnt_r <= {SEL_W{1'b0}};
    end
  end
`endif

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    insuf_nxt_s = 1'b0;
    latch_s     = 1'b0;
    refill_s    = 1'b0;
    load_bout_s = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (refill) begin
          refill_s = 1'b1;
        end else if (meal_request) begin
          latch_s = 1'b1;
          if ({1'b0, user_id} >= USERS_W) begin
            state_nxt_s = ST_REJECT;
          end else begin
            state_nxt_s = ST_AUTH;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AUTH: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RECOMMEND;
          load_bout_s = 1'b1;
        end else begin
          state_nxt_s = ST_AUTH;
        end
      end
      ST_RECOMMEND: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (user_select) begin
          if (sel_bal_s >= cost_r) begin
            state_nxt_s = ST_TRANSACTION;
          end else begin
            state_nxt_s = ST_REJECT;
            insuf_nxt_s = 1'b1;
          end
`ifdef CREDIT_SEL_TIMEOUT_EN
        end else if (sel_cnt_r == SEL_LAST) begin
          state_nxt_s = ST_REJECT;
`endif
        end else begin
          state_nxt_s = ST_RECOMMEND;
        end
      end
      ST_TRANSACTION: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_UPDATE;
          commit_s    = 1'b1;
        end else begin
          state_nxt_s = ST_TRANSACTION;
        end
      end
      ST_UPDATE:  state_nxt_s = ST_IDLE;
      ST_REJECT:  state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, dwell counter, latched request and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      uid_r   <= {IDW{1'b0}};
      cost_r  <= {CREDIT_W{1'b0}};
      bout_r  <= {CREDIT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ok_r    <= 1'b0;
      insuf_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // The dwell counter restarts on every state change, so each AUTH/TRANSACTION visit starts at 0.
      if ((state_r == ST_AUTH || state_r == ST_TRANSACTION) && state_nxt_s == state_r) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
      if (latch_s) begin
        uid_r  <= user_id;
        cost_r <= meal_cost;
      end
      if (load_bout_s) begin
        bout_r <= sel_bal_s;
      end else if (commit_s) begin
        bout_r <= new_bal_s;
      end
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_UPDATE) || (state_nxt_s == ST_REJECT);
      ok_r    <= (state_nxt_s == ST_UPDATE);
      insuf_r <= insuf_nxt_s;
    end
  end

  // Per-user balances: bulk saturating refill or single debit on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        bal_r[i] <= RESET_VAL;
      end
    end else if (refill_s) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        bal_r[i] <= sat_add(bal_r[i], refill_amount);
      end
    end else if (commit_s) begin
      bal_r[uid_r] <= new_bal_s;
    end
  end

  assign state        = state_r;
  assign busy         = busy_r;
  assign balance_out  = bout_r;
  assign txn_done     = done_r;
  assign txn_ok       = ok_r;
  assign insufficient = insuf_r;

endmodule

// File: tb/tb_credit_txn_controller.sv
// Bench for credit_txn_controller: directed plan plus randomized traffic against a
// transaction-level model (phase + remaining-cycle countdown, balance array).
module tb_credit_txn_controller;
  localparam int NU  = 5;
  localparam int CW  = 8;
  localparam int AC  = 3;
  localparam int RC  = 255;
  localparam int STO = 4;
  localparam int IDW = $clog2(NU);
  localparam int MAXB = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           meal_request = 1'b0;
  logic [IDW-1:0] user_id = '0;
  logic [CW-1:0]  meal_cost = '0;
  logic           user_select = 1'b0;
  logic           cancel = 1'b0;
  logic           refill = 1'b0;
  logic [CW-1:0]  refill_amount = '0;
  logic [IDW-1:0] query_id = '0;
  logic [CW-1:0]  query_balance;
  logic [2:0]     state;
  logic           busy;
  logic [CW-1:0]  balance_out;
  logic           txn_done;
  logic           txn_ok;
  logic           insufficient;

  credit_txn_controller #(
    .NUM_USERS(NU), .CREDIT_W(CW), .AUTH_CYCLES(AC), .RESET_CREDIT(RC), .SEL_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .meal_request(meal_request), .user_id(user_id),
    .meal_cost(meal_cost), .user_select(user_select), .cancel(cancel), .refill(refill),
    .refill_amount(refill_amount), .query_id(query_id), .query_balance(query_balance),
    .state(state), .busy(busy), .balance_out(balance_out), .txn_done(txn_done),
    .txn_ok(txn_ok), .insufficient(insufficient)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0..5 (IDLE..REJECT), cycles left in the current dwell, balances.
  int m_phase, m_left, m_uid, m_cost, m_bout, m_insuf, m_wait;
  int bal [NU];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_uid = 0; m_cost = 0; m_bout = 0; m_insuf = 0; m_wait = 0;
    for (int i = 0; i < NU; i++) bal[i] = RC;
  endtask

  // One clock of the specified behaviour, evaluated with the inputs present at the edge.
  task automatic model_step();
    case (m_phase)
      0: begin
        if (refill) begin
          for (int i = 0; i < NU; i++)
            bal[i] = (bal[i] + int'(refill_amount) > MAXB) ? MAXB : bal[i] + int'(refill_amount);
        end else if (meal_request) begin
          m_uid = int'(user_id);
          m_cost = int'(meal_cost);
          if (m_uid >= NU) begin m_phase = 5; m_insuf = 0; end
          else begin m_phase = 1; m_left = AC; end
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin m_phase = 2; m_bout = bal[m_uid]; m_wait = 0; end
      end
      2: begin
        m_wait++;
        if (cancel) m_phase = 0;
        else if (user_select) begin
          if (bal[m_uid] >= m_cost) begin m_phase = 3; m_left = AC; end
          else begin m_phase = 5; m_insuf = 1; end
        end
`ifdef CREDIT_SEL_TIMEOUT_EN
        else if (m_wait >= STO) begin m_phase = 5; m_insuf = 0; end
`endif
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          bal[m_uid] = bal[m_uid] - m_cost;
          m_bout = bal[m_uid];
          m_phase = 4;
        end
      end
      default: begin m_phase = 0; m_insuf = 0; end
    endcase
  endtask

  task automatic compare();
    int qexp;
    qexp = (int'(query_id) < NU) ? bal[query_id] : 0;
    chk("state", int'(state), m_phase);
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("txn_done", int'(txn_done), int'(m_phase == 4 || m_phase == 5));
    chk("txn_ok", int'(txn_ok), int'(m_phase == 4));
    chk("insufficient", int'(insufficient), int'(m_phase == 5 && m_insuf == 1));
    chk("balance_out", int'(balance_out), m_bout);
    chk("query_balance", int'(query_balance), qexp);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic request(input int uid, input int cost);
    meal_request = 1'b1;
    user_id = IDW'(uid);
    meal_cost = CW'(cost);
    cycle();
    meal_request = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (txn_done !== 1'b1 && n < budget) begin cycle(); n++; end
    if (txn_done !== 1'b1) bound_fail("wait_done");
  endtask

  task automatic wait_state(input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin cycle(); n++; end
    if (int'(state) != target) bound_fail("wait_state");
  endtask

  task automatic qchk(input string name, input int id, input int exp);
    query_id = IDW'(id);
    #1;
    chk(name, int'(query_balance), exp);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    rst_n = 1'b1;

    // 1: reset while in AUTH
    request(0, 10);
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(txn_done), 0);
    chk("rst_ok", int'(txn_ok), 0);
    chk("rst_insuf", int'(insufficient), 0);
    chk("rst_bout", int'(balance_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NU; i++) qchk("rst_query", i, 255);
    qchk("rst_query_oor", 6, 0);

    // 2: user 2 buys 40; UPDATE is the (2*AC+3)-th cycle counting the request cycle as the first
    user_select = 1'b1;
    request(2, 40);
    wait_done(40, n);
    chk("latency", n + 2, 9);
    chk("t2_ok", int'(txn_ok), 1);
    chk("t2_bout", int'(balance_out), 215);
    qchk("t2_q2", 2, 215);
    qchk("t2_q0", 0, 255);
    user_select = 1'b0;
    cycle();

    // 3: user 1 drops to 55, then a second 200 purchase is rejected
    user_select = 1'b1;
    request(1, 200);
    wait_done(40, n);
    chk("t3_bout", int'(balance_out), 55);
    cycle();
    request(1, 200);
    wait_done(40, n);
    chk("t3_rej_state", int'(state), 5);
    chk("t3_rej_insuf", int'(insufficient), 1);
    chk("t3_rej_ok", int'(txn_ok), 0);
    qchk("t3_q1", 1, 55);
    user_select = 1'b0;
    cycle();

    // 4: cancel beats select
    request(3, 10);
    wait_state(2, 20);
    cancel = 1'b1;
    user_select = 1'b1;
    cycle();
    chk("t4_state", int'(state), 0);
    chk("t4_done", int'(txn_done), 0);
    cancel = 1'b0;
    user_select = 1'b0;
    qchk("t4_q3", 3, 255);

    // 5: saturating refill, then a refill held during AUTH is ignored
    refill = 1'b1;
    refill_amount = 8'd100;
    cycle();
    refill = 1'b0;
    qchk("t5_q1", 1, 155);
    qchk("t5_q2", 2, 255);
    qchk("t5_q0", 0, 255);
    request(1, 5);
    refill = 1'b1;
    cycle();
    cycle();
    refill = 1'b0;
    qchk("t5_q1_auth", 1, 155);
    wait_state(2, 20);
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;

    // 6: out-of-range ID rejects right after the request cycle
    request(6, 1);
    chk("t6_state", int'(state), 5);
    chk("t6_done", int'(txn_done), 1);
    chk("t6_insuf", int'(insufficient), 0);
    cycle();
`ifdef CREDIT_SEL_TIMEOUT_EN
    request(0, 1);
    wait_state(2, 20);
    n = 0;
    while (int'(state) == 2 && n < 20) begin cycle(); n++; end
    chk("t6_tmo_cycles", n, STO);
    chk("t6_tmo_state", int'(state), 5);
    chk("t6_tmo_insuf", int'(insufficient), 0);
    cycle();
`endif

    // Randomized traffic, including occasional asynchronous resets
    for (int k = 0; k < 2500; k++) begin
      meal_request  = ($urandom_range(0, 9) < 3);
      user_id       = IDW'($urandom_range(0, (1 << IDW) - 1));
      meal_cost     = CW'($urandom_range(0, 130));
      user_select   = ($urandom_range(0, 9) < 3);
      cancel        = ($urandom_range(0, 19) == 0);
      refill        = ($urandom_range(0, 29) == 0);
      refill_amount = CW'($urandom_range(0, 255));
      query_id      = IDW'($urandom_range(0, (1 << IDW) - 1));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
